// File: rtl/multiword_add_sequencer_if.sv
// Handshake and operand/result bundle for the multi-word add/subtract sequencer.
// The master side issues requests; the slave side is the sequencer itself.
interface multiword_add_sequencer_if #(
   parameter int unsigned WORDS = 4
);
   localparam int unsigned W = 16 * WORDS;

   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/multiword_add_sequencer.sv
// WORDS x 16-bit add/subtract built from one shared 16-bit carry-chained adder slice.
// Limbs are processed low to high, one per cycle; the result is held until the next start.
module multiword_add_sequencer #(
   parameter int unsigned WORDS = 4
) (
   input logic                       clk,
   input logic                       nrst,
   multiword_add_sequencer_if.slave  bus
);
   localparam int unsigned W    = 16 * WORDS;
   localparam int unsigned IdxW = $clog2(WORDS);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            sub_q;
   logic            c_q;
   logic [IdxW-1:0] idx_q;
   logic [W-1:0]    sum_q;
   logic            cout_q;
   logic            ovf_q;
   logic            busy_q;
   logic            done_q;

   // The single shared adder slice, fed by the limb selected by idx_q.
   logic [IdxW+3:0] lsb;
   logic [15:0]     a_limb;
   logic [15:0]     b_limb;
   logic [16:0]     slice;
   logic            ovf_next;

   always_comb begin
      lsb      = {idx_q, 4'b0000};
      a_limb   = a_q[lsb +: 16];
      b_limb   = b_q[lsb +: 16] ^ {16{sub_q}};
      slice    = {1'b0, a_limb} + {1'b0, b_limb} + {16'd0, c_q};
      // Only meaningful on the top limb, where slice[15] is the new sum MSB.
      ovf_next = (a_q[W-1] == (b_q[W-1] ^ sub_q)) & (slice[15] != a_q[W-1]);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         c_q     <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  sub_q   <= bus.sub;
                  c_q     <= bus.sub;
                  idx_q   <= '0;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  ovf_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               sum_q[lsb +: 16] <= slice[15:0];
               c_q              <= slice[16];
               idx_q            <= idx_q + 1'b1;
               if (idx_q == LastIdx) begin
                  cout_q  <= slice[16];
                  ovf_q   <= ovf_next;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  idx_q   <= '0;
                  state_q <= StDone;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
endmodule
